// File: rtl/pad_test_core_pkg.sv
// Shared types for the pad test core: output mode encoding as seen on the two mode pads.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package chip_core_pkg;

    localparam int MODE_BITS = 2;

    typedef enum logic [MODE_BITS-1:0] {
        PARITY = 2'd0,
        COUNT  = 2'd1,
        LFSR   = 2'd2,
        SHIFT  = 2'd3
    } mode_e;

endpackage

// File: rtl/pad_test_core_if.sv
// Pad bundle between the pad ring (master) and the test core (slave).
// Latency: none, wires only.
// Backpressure: none, pads are free-running.
interface pad_test_core_if #(
    parameter int NUM_INPUT_PADS  = 8,
    parameter int NUM_OUTPUT_PADS = 8
);
    logic [NUM_INPUT_PADS-1:0]  input_in;
    logic [NUM_OUTPUT_PADS-1:0] output_out;

    modport master (output input_in, input output_out);
    modport slave  (input input_in, output output_out);
endinterface

// File: rtl/pad_test_core_sync.sv
// Multi-flop synchroniser covering a whole bus of asynchronous pad inputs.
// Latency: STAGES clock cycles.
// Backpressure: none, samples every cycle.
module pad_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    // Shift the raw pad sample through the chain; stage 0 is the metastable one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pad_test_core.sv
// Pad test core: synchronised input pads drive output pads in PARITY/COUNT/LFSR/SHIFT mode.
// Latency: PARITY SYNC_STAGES+1 cycles pad-to-pad, SHIFT SYNC_STAGES+2; COUNT/LFSR trail state by 1.
// Backpressure: none, outputs update every cycle; a mode change costs one all-zero clear cycle.
module pad_test_core
    import chip_core_pkg::*;
#(
    parameter int                         NUM_INPUT_PADS  = 8,
    parameter int                         NUM_OUTPUT_PADS = 8,
    parameter int                         SYNC_STAGES     = 2,
    parameter logic [NUM_OUTPUT_PADS-1:0] LFSR_SEED       = 8'h01,
    parameter logic [NUM_OUTPUT_PADS-1:0] LFSR_TAPS       = 8'hB8
) (
    input  logic            clk,
    input  logic            rst_n,
    pad_test_core_if.slave  pads
);

    localparam int DW = NUM_INPUT_PADS - MODE_BITS;
    localparam int OW = NUM_OUTPUT_PADS;

    // Reject parameter sets the datapath cannot support.
    if (NUM_INPUT_PADS < 3) begin : g_bad_in
        $error("NUM_INPUT_PADS must be at least 3");
    end
    if (NUM_OUTPUT_PADS < 2) begin : g_bad_out
        $error("NUM_OUTPUT_PADS must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero, an all-zero LFSR never leaves zero");
    end

    logic [NUM_INPUT_PADS-1:0] w_sync;
    mode_e                     w_mode_s;
    logic [DW-1:0]             w_data_s;

    mode_e                     r_mode_q;
    logic [OW-1:0]             r_count;
    logic [OW-1:0]             r_lfsr;
    logic [OW-1:0]             r_shift;
    logic [OW-1:0]             r_out;

    mode_e                     w_mode_nxt;
    logic [OW-1:0]             w_count_nxt;
    logic [OW-1:0]             w_lfsr_nxt;
    logic [OW-1:0]             w_shift_nxt;
    logic [OW-1:0]             w_out_nxt;

    pad_sync #(
        .WIDTH  (NUM_INPUT_PADS),
        .STAGES (SYNC_STAGES)
    ) u_pad_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pads.input_in),
        .o_q   (w_sync)
    );

    assign w_mode_s = mode_e'(w_sync[MODE_BITS-1:0]);
    assign w_data_s = w_sync[NUM_INPUT_PADS-1:MODE_BITS];

    // Next state: a mode mismatch is a clear cycle, otherwise only the active mode's state advances.
    always_comb begin
        w_mode_nxt  = r_mode_q;
        w_count_nxt = r_count;
        w_lfsr_nxt  = r_lfsr;
        w_shift_nxt = r_shift;
        w_out_nxt   = r_out;
        if (w_mode_s != r_mode_q) begin
            // Events landing on the clear cycle are dropped on purpose.
            w_mode_nxt  = w_mode_s;
            w_count_nxt = '0;
            w_lfsr_nxt  = LFSR_SEED;
            w_shift_nxt = '0;
            w_out_nxt   = '0;
        end else begin
            case (r_mode_q)
                PARITY: begin
                    w_out_nxt = {OW{^w_data_s}};
                end
                COUNT: begin
                    w_out_nxt = r_count;
                    if (&w_data_s) begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
                LFSR: begin
                    w_out_nxt  = r_lfsr;
                    w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
                end
                SHIFT: begin
                    w_out_nxt   = r_shift;
                    w_shift_nxt = {r_shift[OW-2:0], w_data_s[0]};
                end
                default: begin
                    w_out_nxt = '0;
                end
            endcase
        end
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_q <= PARITY;
            r_count  <= '0;
            r_lfsr   <= LFSR_SEED;
            r_shift  <= '0;
            r_out    <= '0;
        end else begin
            r_mode_q <= w_mode_nxt;
            r_count  <= w_count_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_shift  <= w_shift_nxt;
            r_out    <= w_out_nxt;
        end
    end

    // Output pads come straight from a flop so they never glitch.
    assign pads.output_out = r_out;

endmodule
